// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus stage: FSM encoding, wait counter
// width and the slow-window address match.
package cpu_bus_pkg;

    // RUN: accesses commit on each enable; WAIT: core held for a slow access.
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Wait-state counter width; SLOW_WAIT must fit in it.
    localparam int WAIT_CW = 4;

    // True when every address bit selected by mask equals the base bit.
    // Operands are zero-extended to 32 bits, so addresses up to 32 bits compare in full.
    function automatic logic slow_match(input logic [31:0] ab,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return ((ab ^ base) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/cpu_bus_stage_if.sv
// Core-side and system-bus-side signals of the CPU bus stage.
//
// Handshake: core_rdy is combinational from the stage. An access is taken
// (committed) on a clock edge where enable and core_rdy are both high; the
// core must keep core_ab/core_do/core_we stable until that edge. bus_ready
// low withholds core_rdy. bus_ab/bus_dbo/bus_we change only on a commit.
interface cpu_bus_stage_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic [AW-1:0] core_ab;
    logic [DW-1:0] core_do;
    logic          core_we;
    logic [AW-1:0] core_pc;
    logic          core_rdy;
    logic [AW-1:0] bus_ab;
    logic [DW-1:0] bus_dbo;
    logic          bus_we;
    logic          bus_ready;
    logic          dbg_state;   // current FSM state (0 = RUN, 1 = WAIT)

    // Core and system-bus side: drives the core outputs and bus_ready.
    modport master (
        output core_ab, core_do, core_we, core_pc, bus_ready,
        input  core_rdy, bus_ab, bus_dbo, bus_we, dbg_state
    );

    // The bus stage itself.
    modport slave (
        input  core_ab, core_do, core_we, core_pc, bus_ready,
        output core_rdy, bus_ab, bus_dbo, bus_we, dbg_state
    );
endinterface

// File: rtl/cpu_trace_fifo.sv
// Program-counter trace ring buffer. First-word-fall-through read port
// (rd_data is 0 when empty). A push into a full buffer without a pop drops
// the oldest entry and sets the sticky ovf flag; push+pop when full keeps
// the count and does not flag overflow. Pops on an empty buffer are ignored.
module cpu_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_req,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cpu_trace_fifo: DEPTH must be a power of two >= 2");
    end

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          full;
    logic          pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop     = pop_req & ~empty;
    assign rd_data = empty ? '0 : mem_q[rd_q];
    assign ovf     = ovf_q;

    // Pointer, occupancy and overflow bookkeeping; pointers wrap naturally.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push) wr_d = wr_q + 1'b1;
        if (pop)  rd_d = rd_q + 1'b1;
        if (push && !pop) begin
            if (full) begin
                rd_d  = rd_q + 1'b1;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/cpu_bus_stage.sv
// Registered bus stage between a 6502-class core and the system bus.
// Registers address/data/write strobe on commit, inserts wait states for a
// slow address window, synchronises IRQ/NMI and, when the CPU_TRACE_EN
// macro is defined, records a program-counter trace (otherwise the trace
// port reads as permanently empty).
module cpu_bus_stage
    import cpu_bus_pkg::*;
#(
    parameter int            AW          = 16,
    parameter int            DW          = 8,
    parameter logic [AW-1:0] SLOW_BASE   = AW'(16'hD000),
    parameter logic [AW-1:0] SLOW_MASK   = AW'(16'hF000),
    parameter int            SLOW_WAIT   = 2,
    parameter int            SYNC_STAGES = 2,
    parameter int            TRACE_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    cpu_bus_stage_if.slave  bus,
    input  logic            irq_n,
    input  logic            nmi_n,
    output logic            core_irq,
    output logic            core_nmi,
    input  logic            trace_rd,
    output logic [AW-1:0]   trace_data,
    output logic            trace_empty,
    output logic            trace_ovf
);

    if (SLOW_WAIT < 0 || SLOW_WAIT > 15) begin : g_bad_wait
        $error("cpu_bus_stage: SLOW_WAIT must be in 0..15");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("cpu_bus_stage: SYNC_STAGES must be >= 2");
    end

    localparam logic [WAIT_CW-1:0] WAIT_LOAD = WAIT_CW'(SLOW_WAIT);
    localparam logic               STALL_EN  = (SLOW_WAIT != 0);

    logic [0:0]         state_q, state_d;
    logic [WAIT_CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]      ab_q, ab_d;
    logic [DW-1:0]      dbo_q, dbo_d;
    logic               we_q, we_d;
    logic               commit;
    logic               slow_hit;

    assign bus.core_rdy  = (state_q == ST_RUN) & bus.bus_ready;
    assign commit        = enable & bus.core_rdy;
    assign slow_hit      = slow_match(32'(bus.core_ab), 32'(SLOW_BASE), 32'(SLOW_MASK));
    assign bus.bus_ab    = ab_q;
    assign bus.bus_dbo   = dbo_q;
    assign bus.bus_we    = we_q;
    assign bus.dbg_state = state_q[0];

    // Next state: capture on commit, enter WAIT for slow addresses, count down wait enables.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ab_d    = ab_q;
        dbo_d   = dbo_q;
        we_d    = we_q;
        if (commit) begin
            ab_d  = bus.core_ab;
            dbo_d = bus.core_do;
            we_d  = bus.core_we;
            if (slow_hit && STALL_EN) begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_LOAD;
            end
        end else if (enable && state_q == ST_WAIT) begin
            if (cnt_q == WAIT_CW'(1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Bus registers and FSM; reset abandons any access in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            ab_q    <= '0;
            dbo_q   <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ab_q    <= ab_d;
            dbo_q   <= dbo_d;
            we_q    <= we_d;
        end
    end

    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;

    // Interrupt synchroniser shift: runs every clock, not gated by enable.
    always_comb begin
        irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], irq_n};
        nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], nmi_n};
    end

    // Synchroniser flops reset to the inactive (high) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync_q <= '1;
            nmi_sync_q <= '1;
        end else begin
            irq_sync_q <= irq_sync_d;
            nmi_sync_q <= nmi_sync_d;
        end
    end

    assign core_irq = ~irq_sync_q[SYNC_STAGES-1];
    assign core_nmi = ~nmi_sync_q[SYNC_STAGES-1];

`ifdef CPU_TRACE_EN
    logic [AW-1:0] last_pc_q, last_pc_d;
    logic          trace_push;

    assign trace_push = commit & (bus.core_pc != last_pc_q);

    // Remember the last traced PC so straight repeats are not recorded.
    always_comb begin
        last_pc_d = trace_push ? bus.core_pc : last_pc_q;
    end

    // Last traced PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_pc_q <= '0;
        else     last_pc_q <= last_pc_d;
    end

    cpu_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .W     (AW)
    ) u_trace_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (trace_push),
        .push_data (bus.core_pc),
        .pop_req   (enable & trace_rd),
        .rd_data   (trace_data),
        .empty     (trace_empty),
        .ovf       (trace_ovf)
    );
`else
    logic unused_trace;
    assign unused_trace = ^{trace_rd, bus.core_pc};
    assign trace_data   = '0;
    assign trace_empty  = 1'b1;
    assign trace_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_bus_stage.sv
// Bench for cpu_bus_stage: directed scenarios plus randomized traffic,
// a reference model of commit/stall/trace behaviour and a queue scoreboard.
module tb_cpu_bus_stage;

    localparam int AW          = 16;
    localparam int DW          = 8;
    localparam int SLOW_WAIT   = 2;
    localparam int SYNC_STAGES = 2;
    localparam int TRACE_DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          enable   = 1'b0;
    logic          irq_n    = 1'b1;
    logic          nmi_n    = 1'b1;
    logic          trace_rd = 1'b0;
    logic          core_irq, core_nmi;
    logic [AW-1:0] trace_data;
    logic          trace_empty, trace_ovf;

    cpu_bus_stage_if #(.AW(AW), .DW(DW)) bus_if ();

    cpu_bus_stage #(
        .AW          (AW),
        .DW          (DW),
        .SLOW_BASE   (16'hD000),
        .SLOW_MASK   (16'hF000),
        .SLOW_WAIT   (SLOW_WAIT),
        .SYNC_STAGES (SYNC_STAGES),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus_if),
        .irq_n       (irq_n),
        .nmi_n       (nmi_n),
        .core_irq    (core_irq),
        .core_nmi    (core_nmi),
        .trace_rd    (trace_rd),
        .trace_data  (trace_data),
        .trace_empty (trace_empty),
        .trace_ovf   (trace_ovf)
    );

    // ---------------- scoreboard / reference model ----------------
    int                  n_checks = 0;
    int                  n_pass   = 0;
    logic [AW+DW:0]      exp_q[$];
    logic [AW+DW:0]      hold_ref = '0;
    int                  stall_left = 0;   // enables the core is still blocked for
    logic [AW-1:0]       tr_q[$];
    logic [AW-1:0]       tr_last = '0;
    logic                tr_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic in_slow_window(input logic [AW-1:0] ab);
        return (ab >= 16'hD000) && (ab <= 16'hDFFF);
    endfunction

    task automatic check_trace();
`ifdef CPU_TRACE_EN
        check("trace_empty", trace_empty, tr_q.size() == 0);
        check("trace_data", trace_data, (tr_q.size() == 0) ? '0 : tr_q[0]);
        check("trace_ovf", trace_ovf, tr_ovf);
`else
        check("trace_empty", trace_empty, 1'b1);
        check("trace_data", trace_data, 32'h0);
        check("trace_ovf", trace_ovf, 1'b0);
`endif
    endtask

    task automatic model_clear();
        exp_q.delete();
        hold_ref   = '0;
        stall_left = 0;
        tr_q.delete();
        tr_last    = '0;
        tr_ovf     = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic en, input logic [AW-1:0] ab, input logic [DW-1:0] dout,
                               input logic we, input logic rdy, input logic [AW-1:0] pc,
                               input logic trd);
        logic exp_rdy;
        @(negedge clk);
        check_trace();
        enable           = en;
        bus_if.core_ab   = ab;
        bus_if.core_do   = dout;
        bus_if.core_we   = we;
        bus_if.bus_ready = rdy;
        bus_if.core_pc   = pc;
        trace_rd         = trd;
        #1;
        exp_rdy = (stall_left == 0) && rdy;
        check("core_rdy", bus_if.core_rdy, exp_rdy);
        if (en) begin
`ifdef CPU_TRACE_EN
            if (trd && tr_q.size() > 0) tr_q.delete(0);
            if (exp_rdy && pc != tr_last) begin
                if (tr_q.size() == TRACE_DEPTH) begin
                    tr_q.delete(0);
                    tr_ovf = 1'b1;
                end
                tr_q.push_back(pc);
                tr_last = pc;
            end
`endif
            if (exp_rdy) begin
                exp_q.push_back({ab, dout, we});
                if (in_slow_window(ab)) stall_left = SLOW_WAIT;
            end else if (stall_left > 0) begin
                stall_left--;
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_bus_ab", bus_if.bus_ab, 32'h0);
        check("rst_bus_dbo", bus_if.bus_dbo, 32'h0);
        check("rst_bus_we", bus_if.bus_we, 32'h0);
        check("rst_core_irq", core_irq, 32'h0);
        check("rst_core_nmi", core_nmi, 32'h0);
        check("rst_state", bus_if.dbg_state, 32'h0);
        check("rst_trace_empty", trace_empty, 32'h1);
        check("rst_trace_data", trace_data, 32'h0);
        check("rst_trace_ovf", trace_ovf, 32'h0);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic pulse_reset();
        @(posedge clk);
        #2;
        check("pre_rst_state", bus_if.dbg_state, stall_left > 0);
        enable = 1'b0;
        rst    = 1'b1;
        #1;
        model_clear();
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic           mon_fire;
    logic [AW+DW:0] mon_exp;
    always @(posedge clk) begin
        mon_fire = enable & bus_if.core_rdy & ~rst;
        #1;
        if (mon_fire) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL bus_commit: unexpected commit bus=%h expected none", {bus_if.bus_ab, bus_if.bus_dbo, bus_if.bus_we});
            end else begin
                mon_exp  = exp_q.pop_front();
                hold_ref = mon_exp;
                check("bus_commit", {bus_if.bus_ab, bus_if.bus_dbo, bus_if.bus_we}, mon_exp);
            end
        end else begin
            check("bus_hold", {bus_if.bus_ab, bus_if.bus_dbo, bus_if.bus_we}, hold_ref);
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] r_ab;
        bus_if.core_ab   = '0;
        bus_if.core_do   = '0;
        bus_if.core_we   = 1'b0;
        bus_if.core_pc   = '0;
        bus_if.bus_ready = 1'b1;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        check("rst_core_rdy", bus_if.core_rdy, 32'h1);
        rst = 1'b0;

        // 1: fast write, enable every clock
        drive_cycle(1'b1, 16'h0300, 8'h55, 1'b1, 1'b1, 16'h0100, 1'b0);
        drive_cycle(1'b1, 16'h0301, 8'hA0, 1'b0, 1'b1, 16'h0101, 1'b0);

        // 2: slow access, enable every other clock, address changes while stalled
        drive_cycle(1'b1, 16'hD010, 8'h11, 1'b1, 1'b1, 16'h0102, 1'b0);
        for (int i = 0; i < 6; i++)
            drive_cycle(i[0], 16'h0400 + 16'(i), 8'h20, 1'b0, 1'b1, 16'h0103, 1'b0);

        // 3: bus_ready low for three clocks, then resume
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 16'h0500, 8'h33, 1'b1, 1'b0, 16'h0104, 1'b0);
        drive_cycle(1'b1, 16'h0500, 8'h33, 1'b1, 1'b1, 16'h0105, 1'b0);

        // 4: interrupt synchronisers with enable low
        @(negedge clk);
        enable = 1'b0;
        irq_n  = 1'b0;
        for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
            @(posedge clk); #1;
            check("irq_assert", core_irq, k >= SYNC_STAGES);
            check("nmi_quiet", core_nmi, 32'h0);
        end
        @(negedge clk);
        irq_n = 1'b1;
        nmi_n = 1'b0;
        for (int k = 1; k <= SYNC_STAGES + 1; k++) begin
            @(posedge clk); #1;
            check("irq_release", core_irq, k < SYNC_STAGES);
            check("nmi_assert", core_nmi, k >= SYNC_STAGES);
        end
        @(negedge clk);
        nmi_n = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk);
        #1;
        check("nmi_release", core_nmi, 32'h0);

`ifdef CPU_TRACE_EN
        // 5: 17 distinct PCs overflow the trace, a repeat is not pushed, then pops
        for (int i = 0; i < 17; i++)
            drive_cycle(1'b1, 16'h0600 + 16'(i), 8'h01, 1'b0, 1'b1, 16'h2000 + 16'(3 * i), 1'b0);
        drive_cycle(1'b1, 16'h0700, 8'h02, 1'b0, 1'b1, 16'h2030, 1'b0);
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 16'h0701, 8'h03, 1'b0, 1'b1, 16'h2030, 1'b1);
        drive_cycle(1'b0, 16'h0701, 8'h03, 1'b0, 1'b1, 16'h2030, 1'b1);
`endif

        // 6: reset while waiting on a slow access
        drive_cycle(1'b1, 16'hD123, 8'h77, 1'b1, 1'b1, 16'h0200, 1'b0);
        pulse_reset();
        drive_cycle(1'b1, 16'h0800, 8'h44, 1'b0, 1'b1, 16'h0201, 1'b0);
        drive_cycle(1'b1, 16'h0801, 8'h45, 1'b1, 1'b0, 16'h0202, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            r_ab = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) r_ab = 16'hD000 | 16'($urandom_range(0, 4095));
            drive_cycle($urandom_range(0, 9) < 7, r_ab, 8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 9) < 8,
                        16'h8000 + 16'($urandom_range(0, 40)), $urandom_range(0, 3) == 0);
        end

        // Drain and final scoreboard check
        repeat (3) drive_cycle(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b0);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
